// File: rtl/servo_pwm_hbridge.sv
// H-bridge PWM output stage: latches the signed control effort into shadow registers,
// applies it at each PWM period boundary, and inserts a dead-time guard on reversals.
module servo_pwm_hbridge #(
    parameter int N_BITS   = 13,
    parameter int PWM_BITS = 10,
    parameter int SHIFT    = 2,
    parameter int DEAD_CYC = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                drive_en,
    input  logic [N_BITS-1:0]   u_in,
    input  logic                u_valid,
    output logic                pwm_a,
    output logic                pwm_b,
    output logic                dir,
    output logic [PWM_BITS-1:0] duty,
    output logic                period_tick
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_DEAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [PWM_BITS-1:0] CNT_MAX    = '1;
    localparam logic [PWM_BITS-1:0] CNT_PRE    = CNT_MAX - PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] DEAD_LIM   = PWM_BITS'(DEAD_CYC);
    localparam logic [N_BITS-1:0]   MAG_MAX    = {1'b0, {(N_BITS-1){1'b1}}};
    localparam logic [N_BITS-1:0]   DUTY_LIM_N = N_BITS'(CNT_MAX);

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] sh_duty_q, sh_duty_d;
    logic                sh_dir_q, sh_dir_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                dir_q, dir_d;
    state_t              state_q, state_d;
    logic                pwm_a_q, pwm_a_d;
    logic                pwm_b_q, pwm_b_d;
    logic                tick_q, tick_d;

    logic                wrap;
    logic                leg_on;
    logic [N_BITS-1:0]   mag_raw;
    logic [N_BITS-1:0]   mag;
    logic [N_BITS-1:0]   mag_sh;
    logic [PWM_BITS-1:0] sat_duty;

    // The most negative input negates to itself; it reads as 2**(N_BITS-1) unsigned
    // and is clamped back to the largest positive magnitude.
    always_comb begin
        mag_raw  = u_in[N_BITS-1] ? (~u_in + N_BITS'(1)) : u_in;
        mag      = (mag_raw > MAG_MAX) ? MAG_MAX : mag_raw;
        mag_sh   = mag >> SHIFT;
        sat_duty = (mag_sh > DUTY_LIM_N) ? CNT_MAX : mag_sh[PWM_BITS-1:0];
    end

    always_comb begin
        wrap      = (cnt_q == CNT_MAX);
        cnt_d     = cnt_q + PWM_BITS'(1);
        tick_d    = (cnt_q == CNT_PRE);
        duty_d    = wrap ? sh_duty_q : duty_q;
        dir_d     = wrap ? sh_dir_q : dir_q;
        sh_duty_d = sh_duty_q;
        sh_dir_d  = sh_dir_q;
        if (u_valid) begin
            sh_duty_d = sat_duty;
            // A zero effort keeps the previous direction so it never forces a reversal.
            if (|u_in) begin
                sh_dir_d = u_in[N_BITS-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (!drive_en) begin
            state_d = ST_OFF;
        end else if (wrap) begin
            case (state_q)
                ST_OFF:  state_d = ST_DEAD;
                ST_DEAD,
                ST_RUN:  state_d = (sh_dir_q != dir_q) ? ST_DEAD : ST_RUN;
                default: state_d = ST_OFF;
            endcase
        end
    end

    // drive_en gates the legs directly so a drop turns them off on the very next edge.
    always_comb begin
        leg_on  = drive_en && (state_q != ST_OFF) && (cnt_q < duty_q)
                  && !((state_q == ST_DEAD) && (cnt_q < DEAD_LIM));
        pwm_a_d = leg_on & ~dir_q;
        pwm_b_d = leg_on & dir_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            sh_duty_q <= '0;
            sh_dir_q  <= 1'b0;
            duty_q    <= '0;
            dir_q     <= 1'b0;
            state_q   <= ST_OFF;
            pwm_a_q   <= 1'b0;
            pwm_b_q   <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sh_duty_q <= sh_duty_d;
            sh_dir_q  <= sh_dir_d;
            duty_q    <= duty_d;
            dir_q     <= dir_d;
            state_q   <= state_d;
            pwm_a_q   <= pwm_a_d;
            pwm_b_q   <= pwm_b_d;
            tick_q    <= tick_d;
        end
    end

    assign pwm_a       = pwm_a_q;
    assign pwm_b       = pwm_b_q;
    assign dir         = dir_q;
    assign duty        = duty_q;
    assign period_tick = tick_q;

endmodule

// File: tb/tb_servo_pwm_hbridge.sv
// Bench for servo_pwm_hbridge: directed scenarios plus random effort/enable traffic,
// checked cycle by cycle against a period-level behavioural model.
module tb_servo_pwm_hbridge;

    localparam int PERIOD   = 1024;
    localparam int DEAD_CYC = 8;
    localparam int M_OFF    = 0;
    localparam int M_DEAD   = 1;
    localparam int M_RUN    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        drive_en = 1'b0;
    logic [12:0] u_in = '0;
    logic        u_valid = 1'b0;
    logic        pwm_a, pwm_b, dir, period_tick;
    logic [9:0]  duty;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_on  = 1'b0;

    servo_pwm_hbridge dut (
        .clk        (clk),
        .rst        (rst),
        .drive_en   (drive_en),
        .u_in       (u_in),
        .u_valid    (u_valid),
        .pwm_a      (pwm_a),
        .pwm_b      (pwm_b),
        .dir        (dir),
        .duty       (duty),
        .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: position in period, applied and pending settings, mode.
    int m_cnt = 0;
    int m_sh_duty = 0;
    int m_duty = 0;
    int m_mode = M_OFF;
    int m_next;
    int m_v;
    int m_mag;
    bit m_sh_dir = 1'b0;
    bit m_dir = 1'b0;
    bit m_a = 1'b0;
    bit m_b = 1'b0;
    bit m_on;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt = 0; m_sh_duty = 0; m_duty = 0; m_mode = M_OFF;
            m_sh_dir = 1'b0; m_dir = 1'b0; m_a = 1'b0; m_b = 1'b0;
        end else begin
            m_on = drive_en && (m_mode != M_OFF) && (m_cnt < m_duty)
                   && !(m_mode == M_DEAD && m_cnt < DEAD_CYC);
            m_a = m_on && !m_dir;
            m_b = m_on && m_dir;
            m_next = m_mode;
            if (m_cnt == PERIOD - 1) begin
                if (m_mode == M_OFF) m_next = M_DEAD;
                else m_next = (m_sh_dir != m_dir) ? M_DEAD : M_RUN;
                m_duty = m_sh_duty;
                m_dir  = m_sh_dir;
                m_cnt  = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
            m_mode = drive_en ? m_next : M_OFF;
            if (u_valid) begin
                m_v   = $signed(u_in);
                m_mag = (m_v < 0) ? -m_v : m_v;
                if (m_mag > 4095) m_mag = 4095;
                m_sh_duty = (m_mag / 4 > PERIOD - 1) ? PERIOD - 1 : m_mag / 4;
                if (m_v != 0) m_sh_dir = (m_v < 0);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("pwm_a", int'(pwm_a), int'(m_a));
            check("pwm_b", int'(pwm_b), int'(m_b));
            check("dir", int'(dir), int'(m_dir));
            check("duty", int'(duty), m_duty);
            check("period_tick", int'(period_tick), int'(m_cnt == PERIOD - 1));
            check("legs_exclusive", int'(pwm_a & pwm_b), 0);
        end
    end

    task automatic pulse(input int v);
        u_in    = 13'(v);
        u_valid = 1'b1;
        $display("txn u_in=%0d cnt=%0d drive_en=%0d t=%0t", v, m_cnt, drive_en, $time);
        @(negedge clk);
        u_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int target);
        int n = 0;
        while (m_cnt != target && n < 2 * PERIOD + 50) begin
            @(negedge clk);
            n++;
        end
        if (m_cnt != target) check("wait_cnt_timeout", m_cnt, target);
    endtask

    task automatic wait_wrap();
        @(negedge clk);
        wait_cnt(0);
    endtask

    task automatic count_period(output int na, output int nb);
        na = 0;
        nb = 0;
        for (int i = 0; i < PERIOD; i++) begin
            na += int'(pwm_a);
            nb += int'(pwm_b);
            @(negedge clk);
        end
    endtask

    initial begin
        int na, nb, r, v;

        repeat (3) @(negedge clk);
        check("rst_pwm_a", int'(pwm_a), 0);
        check("rst_pwm_b", int'(pwm_b), 0);
        check("rst_duty", int'(duty), 0);
        check("rst_dir", int'(dir), 0);
        check("rst_tick", int'(period_tick), 0);
        chk_on = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk);

        // Forward effort 400: first drive is a guarded period, then full RUN pulse.
        drive_en = 1'b1;
        pulse(400);
        wait_wrap();
        count_period(na, nb);
        check("first_dead_a", na, 100 - DEAD_CYC);
        count_period(na, nb);
        check("run100_a", na, 100);
        check("run100_b", nb, 0);

        // Reset mid-pulse clears everything immediately.
        wait_cnt(50);
        check("pre_rst_pwm_a", int'(pwm_a), 1);
        #2 rst = 1'b0;
        #1;
        check("arst_pwm_a", int'(pwm_a), 0);
        check("arst_pwm_b", int'(pwm_b), 0);
        check("arst_duty", int'(duty), 0);
        check("arst_dir", int'(dir), 0);
        check("arst_tick", int'(period_tick), 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        pulse(400);
        wait_wrap();
        count_period(na, nb);
        check("post_rst_dead_a", na, 100 - DEAD_CYC);
        count_period(na, nb);
        check("post_rst_run_a", na, 100);

        // Full-scale negative reversal.
        pulse(-4096);
        wait_wrap();
        check("rev_dir", int'(dir), 1);
        check("rev_duty", int'(duty), 1023);
        count_period(na, nb);
        check("rev_dead_a", na, 0);
        check("rev_dead_b", nb, 1023 - DEAD_CYC);
        count_period(na, nb);
        check("rev_run_b", nb, 1023);

        // Capture in the wrap cycle is deferred by one period.
        wait_cnt(PERIOD - 1);
        check("tick_at_max", int'(period_tick), 1);
        pulse(800);
        check("wrapcap_duty_hold", int'(duty), 1023);
        check("wrapcap_dir_hold", int'(dir), 1);
        wait_wrap();
        check("wrapcap_duty", int'(duty), 200);
        check("wrapcap_dir", int'(dir), 0);
        count_period(na, nb);
        check("wrapcap_dead_a", na, 200 - DEAD_CYC);

        // Zero effort after negative effort keeps the direction.
        pulse(-400);
        wait_wrap();
        wait_wrap();
        pulse(0);
        wait_wrap();
        check("zero_duty", int'(duty), 0);
        check("zero_dir", int'(dir), 1);
        count_period(na, nb);
        check("zero_legs", na + nb, 0);
        pulse(-400);
        wait_wrap();
        count_period(na, nb);
        check("zero_no_dead_b", nb, 100);

        // Enable drop mid-pulse, then re-raise.
        wait_cnt(50);
        check("pre_drop_pwm_b", int'(pwm_b), 1);
        drive_en = 1'b0;
        @(negedge clk);
        check("drop_pwm_b", int'(pwm_b), 0);
        wait_cnt(300);
        drive_en = 1'b1;
        wait_wrap();
        count_period(na, nb);
        check("reraise_dead_b", nb, 100 - DEAD_CYC);

        // Random effort and enable traffic.
        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                r = int'($urandom_range(0, 9));
                if (r == 0) v = -4096;
                else if (r == 1) v = 0;
                else v = int'($urandom_range(0, 8191)) - 4096;
                pulse(v);
            end else if ($urandom_range(0, 2499) == 0) begin
                drive_en = ~drive_en;
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
